// File: rtl/fetch_receive_tagged_pkg.sv
// Shared helpers for the tagged fetch-receive buffer.
// Tag layout everywhere is {epoch, slot}: epoch in the MSBs, slot index in the LSBs.
package fetch_receive_tagged_pkg;

  // Number of byte-offset bits within one cache line.
  function automatic int line_offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  // Width of the 32-bit word index inside a line; at least 1 so ports stay non-empty.
  function automatic int word_sel_width(input int line_width);
    return (line_offset_bits(line_width) > 2) ? line_offset_bits(line_width) - 2 : 1;
  endfunction

endpackage

// File: rtl/fetch_receive_tagged_word_select.sv
// Combinational line -> 32-bit word mux, indexed by the PC word offset.
// Padded to a power-of-two table so the index is always in range, even for 32-bit lines.
module fetch_word_select
  import fetch_receive_tagged_pkg::*;
#(
  parameter int LINE_WIDTH = 64,
  localparam int SEL_W = word_sel_width(LINE_WIDTH)
) (
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic [SEL_W-1:0]      word_idx_i,
  output logic [31:0]           word_o
);

  localparam int WORDS   = LINE_WIDTH / 32;
  localparam int ENTRIES = 1 << SEL_W;

  logic [31:0] words [ENTRIES];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_word
    if (gi < WORDS) begin : g_real
      assign words[gi] = line_i[gi*32 +: 32];
    end else begin : g_pad
      assign words[gi] = 32'h0;
    end
  end

  assign word_o = words[word_idx_i];

endmodule

// File: rtl/fetch_receive_tagged.sv
// Tagged I-cache fetch-receive reorder buffer: responses matched by {epoch, slot}, released in order.
// Optional same-cycle response forwarding to decode when FETCH_RECV_BYPASS_EN is defined.
module fetch_receive_tagged
  import fetch_receive_tagged_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int SLOT_WIDTH  = 3,
  parameter int LINE_WIDTH  = 64,
  parameter int EPOCH_WIDTH = 2,
  localparam int TAG_WIDTH  = EPOCH_WIDTH + SLOT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_issue_valid,
  output logic                  fetch_issue_ready,
  input  logic [XLEN-1:0]       fetch_issue_PC,
  input  logic                  fetch_issue_NLP_BTB_hit,
  output logic [TAG_WIDTH-1:0]  fetch_issue_tag,
  input  logic                  fetch_response_valid,
  output logic                  fetch_response_ready,
  input  logic [LINE_WIDTH-1:0] fetch_response_instruction,
  input  logic [TAG_WIDTH-1:0]  fetch_response_tag,
  output logic                  decode_issue_valid,
  input  logic                  decode_issue_ready,
  output logic [31:0]           decode_issue_instruction,
  output logic [XLEN-1:0]       decode_issue_PC,
  output logic                  decode_issue_NLP_BTB_hit,
  input  logic                  flush,
  output logic [SLOT_WIDTH:0]   occupancy
);

  localparam int SLOTS    = 1 << SLOT_WIDTH;
  localparam int OFF_BITS = line_offset_bits(LINE_WIDTH);
  localparam int SEL_W    = word_sel_width(LINE_WIDTH);
  localparam logic [SLOT_WIDTH:0] FULL_COUNT = (SLOT_WIDTH + 1)'(SLOTS);

  logic [SLOT_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [SLOT_WIDTH:0]    count_q, count_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic [SLOTS-1:0]       issued_q, issued_d, received_q, received_d;
  logic [SLOTS-1:0]       btb_q;
  logic [XLEN-1:0]        pc_q    [SLOTS];
  logic [31:0]            instr_q [SLOTS];

  logic [EPOCH_WIDTH-1:0] resp_epoch;
  logic [SLOT_WIDTH-1:0]  resp_slot;
  logic [SEL_W-1:0]       resp_word_idx;
  logic [31:0]            resp_word;
  logic issue_fire, resp_accept, bypass_hit, pop_fire;

  assign {resp_epoch, resp_slot} = fetch_response_tag;

  // The word offset comes from the PC recorded for the responding slot, not from the response.
  if (OFF_BITS > 2) begin : g_idx
    assign resp_word_idx = pc_q[resp_slot][OFF_BITS-1:2];
  end else begin : g_idx0
    assign resp_word_idx = '0;
  end

  fetch_word_select #(.LINE_WIDTH(LINE_WIDTH)) u_word_select (
    .line_i     (fetch_response_instruction),
    .word_idx_i (resp_word_idx),
    .word_o     (resp_word)
  );

  assign fetch_issue_ready    = (count_q != FULL_COUNT) && !flush;
  assign fetch_response_ready = 1'b1;
  assign issue_fire  = fetch_issue_valid && fetch_issue_ready;
  assign resp_accept = fetch_response_valid && (resp_epoch == epoch_q) && issued_q[resp_slot]
                       && !received_q[resp_slot] && !flush;

`ifdef FETCH_RECV_BYPASS_EN
  assign bypass_hit = resp_accept && (resp_slot == head_q);
`else
  assign bypass_hit = 1'b0;
`endif

  assign decode_issue_valid       = (received_q[head_q] || bypass_hit) && (count_q != '0) && !flush;
  assign pop_fire                 = decode_issue_valid && decode_issue_ready;
  assign decode_issue_instruction = bypass_hit ? resp_word : instr_q[head_q];
  assign decode_issue_PC          = pc_q[head_q];
  assign decode_issue_NLP_BTB_hit = btb_q[head_q];
  assign fetch_issue_tag          = {epoch_q, tail_q};
  assign occupancy                = count_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    epoch_d    = epoch_q;
    issued_d   = issued_q;
    received_d = received_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      epoch_d    = epoch_q + 1'b1;
      issued_d   = '0;
      received_d = '0;
    end else begin
      // A forwarded response that is consumed immediately never needs to be marked received.
      if (resp_accept && !(bypass_hit && pop_fire)) received_d[resp_slot] = 1'b1;
      if (pop_fire) begin
        issued_d[head_q]   = 1'b0;
        received_d[head_q] = 1'b0;
        head_d             = head_q + 1'b1;
      end
      if (issue_fire) begin
        issued_d[tail_q]   = 1'b1;
        received_d[tail_q] = 1'b0;
        tail_d             = tail_q + 1'b1;
      end
      case ({issue_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      epoch_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      btb_q      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      epoch_q    <= epoch_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      if (issue_fire) begin
        pc_q[tail_q]  <= fetch_issue_PC;
        btb_q[tail_q] <= fetch_issue_NLP_BTB_hit;
      end
      if (resp_accept) instr_q[resp_slot] <= resp_word;
    end
  end

endmodule

// File: tb/tb_fetch_receive_tagged.sv
// Directed bench for fetch_receive_tagged (default parameters); bypass scenario only with FETCH_RECV_BYPASS_EN.
module tb_fetch_receive_tagged;

`ifdef FETCH_RECV_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_issue_valid, fetch_issue_ready, fetch_issue_NLP_BTB_hit;
  logic [63:0] fetch_issue_PC;
  logic [4:0]  fetch_issue_tag;
  logic        fetch_response_valid, fetch_response_ready;
  logic [63:0] fetch_response_instruction;
  logic [4:0]  fetch_response_tag;
  logic        decode_issue_valid, decode_issue_ready, decode_issue_NLP_BTB_hit;
  logic [31:0] decode_issue_instruction;
  logic [63:0] decode_issue_PC;
  logic        flush;
  logic [3:0]  occupancy;

  int compared   = 0;
  int mismatched = 0;
  int tail_m     = 0;
  logic [1:0] epoch_m = 2'd0;

  fetch_receive_tagged dut (
    .clock(clock), .reset(reset),
    .fetch_issue_valid(fetch_issue_valid), .fetch_issue_ready(fetch_issue_ready),
    .fetch_issue_PC(fetch_issue_PC), .fetch_issue_NLP_BTB_hit(fetch_issue_NLP_BTB_hit),
    .fetch_issue_tag(fetch_issue_tag),
    .fetch_response_valid(fetch_response_valid), .fetch_response_ready(fetch_response_ready),
    .fetch_response_instruction(fetch_response_instruction), .fetch_response_tag(fetch_response_tag),
    .decode_issue_valid(decode_issue_valid), .decode_issue_ready(decode_issue_ready),
    .decode_issue_instruction(decode_issue_instruction), .decode_issue_PC(decode_issue_PC),
    .decode_issue_NLP_BTB_hit(decode_issue_NLP_BTB_hit),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    fetch_issue_valid = 1'b0; fetch_issue_PC = '0; fetch_issue_NLP_BTB_hit = 1'b0;
    fetch_response_valid = 1'b0; fetch_response_instruction = '0; fetch_response_tag = '0;
    decode_issue_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic respond(input logic [4:0] tag, input logic [63:0] line);
    fetch_response_valid = 1'b1; fetch_response_tag = tag; fetch_response_instruction = line;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); tick(); tick(); reset = 1'b0; settle();
    compared++; if (fetch_issue_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", fetch_issue_ready); end
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL reset_dvalid: got %b expected 0", decode_issue_valid); end
    compared++; if (occupancy !== 4'd0) begin mismatched++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    compared++; if (fetch_issue_tag !== 5'd0) begin mismatched++; $display("FAIL reset_tag: got %b expected 00000", fetch_issue_tag); end
    compared++; if (decode_issue_PC !== 64'd0) begin mismatched++; $display("FAIL reset_pc: got %h expected 0", decode_issue_PC); end
    compared++; if (decode_issue_NLP_BTB_hit !== 1'b0) begin mismatched++; $display("FAIL reset_btb: got %b expected 0", decode_issue_NLP_BTB_hit); end
    compared++; if (fetch_response_ready !== 1'b1) begin mismatched++; $display("FAIL reset_rready: got %b expected 1", fetch_response_ready); end
  endtask

  task automatic test_in_order();
    logic [31:0] exp_w [3];
    logic [63:0] line;
    exp_w[0] = 32'h00000013; exp_w[1] = 32'h00100093; exp_w[2] = 32'h00000013;
    line = {32'h00100093, 32'h00000013};
    for (int i = 0; i < 3; i++) begin
      fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h1000 + 64'(4 * i); fetch_issue_NLP_BTB_hit = (i == 1);
      settle();
      compared++; if (fetch_issue_tag !== 5'(i)) begin mismatched++; $display("FAIL inorder_tag%0d: got %b expected %b", i, fetch_issue_tag, 5'(i)); end
      tick();
    end
    idle(); settle();
    compared++; if (occupancy !== 4'd3) begin mismatched++; $display("FAIL inorder_occ: got %0d expected 3", occupancy); end
    for (int i = 0; i < 3; i++) begin
      respond(5'(i), line); settle();
      compared++; if (decode_issue_valid !== BYP) begin mismatched++; $display("FAIL inorder_resp_cycle%0d: got %b expected %b", i, decode_issue_valid, BYP); end
      tick(); fetch_response_valid = 1'b0; settle();
      compared++; if (decode_issue_valid !== 1'b1) begin mismatched++; $display("FAIL inorder_dvalid%0d: got %b expected 1", i, decode_issue_valid); end
      compared++; if (decode_issue_PC !== 64'h1000 + 64'(4 * i)) begin mismatched++; $display("FAIL inorder_pc%0d: got %h expected %h", i, decode_issue_PC, 64'h1000 + 64'(4 * i)); end
      compared++; if (decode_issue_instruction !== exp_w[i]) begin mismatched++; $display("FAIL inorder_instr%0d: got %h expected %h", i, decode_issue_instruction, exp_w[i]); end
      compared++; if (decode_issue_NLP_BTB_hit !== (i == 1)) begin mismatched++; $display("FAIL inorder_btb%0d: got %b expected %b", i, decode_issue_NLP_BTB_hit, (i == 1)); end
      decode_issue_ready = 1'b1; tick(); decode_issue_ready = 1'b0;
    end
    settle();
    compared++; if (occupancy !== 4'd0) begin mismatched++; $display("FAIL inorder_drain_occ: got %0d expected 0", occupancy); end
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL inorder_drain_dvalid: got %b expected 0", decode_issue_valid); end
    tail_m = 3;
  endtask

  task automatic test_reorder();
    int order [4];
    int s0, r;
    logic exp_v;
    logic [31:0] exp_w;
    order[0] = 3; order[1] = 1; order[2] = 0; order[3] = 2;
    s0 = tail_m;
    for (int i = 0; i < 4; i++) begin
      fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h2000 + 64'(4 * i); tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      r = order[k];
      respond({epoch_m, 3'(s0 + r)}, {32'hB0000000 | 32'(r), 32'hA0000000 | 32'(r)});
      settle();
      exp_v = (k == 3) || (k == 2 && BYP);
      compared++; if (decode_issue_valid !== exp_v) begin mismatched++; $display("FAIL reorder_wait%0d: got %b expected %b", k, decode_issue_valid, exp_v); end
      tick();
    end
    fetch_response_valid = 1'b0; decode_issue_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      settle();
      exp_w = ((j % 2) == 1) ? (32'hB0000000 | 32'(j)) : (32'hA0000000 | 32'(j));
      compared++; if (decode_issue_valid !== 1'b1) begin mismatched++; $display("FAIL reorder_dvalid%0d: got %b expected 1", j, decode_issue_valid); end
      compared++; if (decode_issue_PC !== 64'h2000 + 64'(4 * j)) begin mismatched++; $display("FAIL reorder_pc%0d: got %h expected %h", j, decode_issue_PC, 64'h2000 + 64'(4 * j)); end
      compared++; if (decode_issue_instruction !== exp_w) begin mismatched++; $display("FAIL reorder_instr%0d: got %h expected %h", j, decode_issue_instruction, exp_w); end
      tick();
    end
    decode_issue_ready = 1'b0; settle();
    compared++; if (occupancy !== 4'd0) begin mismatched++; $display("FAIL reorder_occ: got %0d expected 0", occupancy); end
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL reorder_empty: got %b expected 0", decode_issue_valid); end
    tail_m = (s0 + 4) % 8;
  endtask

  task automatic test_dup_unissued();
    int s;
    s = tail_m;
    fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h4000; tick(); idle();
    respond({epoch_m, 3'(s)}, {32'h22222222, 32'h11111111}); tick();
    respond({epoch_m, 3'(s)}, {32'h44444444, 32'h33333333}); settle();
    compared++; if (decode_issue_instruction !== 32'h11111111) begin mismatched++; $display("FAIL dup_first: got %h expected 11111111", decode_issue_instruction); end
    tick(); fetch_response_valid = 1'b0; settle();
    compared++; if (decode_issue_instruction !== 32'h11111111) begin mismatched++; $display("FAIL dup_kept: got %h expected 11111111", decode_issue_instruction); end
    decode_issue_ready = 1'b1; tick(); decode_issue_ready = 1'b0;
    respond({epoch_m, 3'(s + 1)}, {32'hDEADBEEF, 32'hDEADBEEF}); settle();
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL unissued_same: got %b expected 0", decode_issue_valid); end
    tick(); fetch_response_valid = 1'b0; settle();
    compared++; if (occupancy !== 4'd0) begin mismatched++; $display("FAIL unissued_occ: got %0d expected 0", occupancy); end
    fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h5000; tick(); idle(); settle();
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL unissued_stale: got %b expected 0", decode_issue_valid); end
    compared++; if (occupancy !== 4'd1) begin mismatched++; $display("FAIL unissued_occ1: got %0d expected 1", occupancy); end
    tail_m = (s + 2) % 8;
  endtask

  task automatic test_flush();
    for (int i = 1; i < 3; i++) begin
      fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h6000 + 64'(4 * i); tick();
    end
    idle(); settle();
    compared++; if (occupancy !== 4'd3) begin mismatched++; $display("FAIL flush_pre_occ: got %0d expected 3", occupancy); end
    flush = 1'b1; fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h9999;
    respond(5'b00000, 64'h0); decode_issue_ready = 1'b1; settle();
    compared++; if (fetch_issue_ready !== 1'b0) begin mismatched++; $display("FAIL flush_ready: got %b expected 0", fetch_issue_ready); end
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL flush_dvalid: got %b expected 0", decode_issue_valid); end
    tick(); idle(); settle();
    compared++; if (occupancy !== 4'd0) begin mismatched++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
    compared++; if (fetch_issue_tag !== 5'b01000) begin mismatched++; $display("FAIL flush_tag: got %b expected 01000", fetch_issue_tag); end
    compared++; if (fetch_issue_ready !== 1'b1) begin mismatched++; $display("FAIL flush_ready_after: got %b expected 1", fetch_issue_ready); end
    epoch_m = 2'd1;
    for (int i = 0; i < 3; i++) begin
      respond({2'b00, 3'(i)}, {32'h0BAD0000, 32'h0BAD0000}); tick();
    end
    idle(); settle();
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL flush_old_dropped: got %b expected 0", decode_issue_valid); end
    fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h6100; tick(); idle();
    respond(5'b00000, {32'h0, 32'h0BAD0001}); tick(); idle(); settle();
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL flush_stale_epoch: got %b expected 0", decode_issue_valid); end
    respond(5'b01000, {32'h0, 32'h600DF00D}); tick(); idle(); settle();
    compared++; if (decode_issue_valid !== 1'b1) begin mismatched++; $display("FAIL flush_new_dvalid: got %b expected 1", decode_issue_valid); end
    compared++; if (decode_issue_instruction !== 32'h600DF00D) begin mismatched++; $display("FAIL flush_new_instr: got %h expected 600df00d", decode_issue_instruction); end
    compared++; if (decode_issue_PC !== 64'h6100) begin mismatched++; $display("FAIL flush_new_pc: got %h expected 6100", decode_issue_PC); end
    decode_issue_ready = 1'b1; tick(); decode_issue_ready = 1'b0;
    tail_m = 1;
  endtask

`ifdef FETCH_RECV_BYPASS_EN
  task automatic test_bypass();
    int s;
    s = tail_m;
    fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h7000; fetch_issue_NLP_BTB_hit = 1'b1; tick(); idle();
    respond({epoch_m, 3'(s)}, {32'h0, 32'h77777777}); decode_issue_ready = 1'b1; settle();
    compared++; if (decode_issue_valid !== 1'b1) begin mismatched++; $display("FAIL bypass_dvalid: got %b expected 1", decode_issue_valid); end
    compared++; if (decode_issue_instruction !== 32'h77777777) begin mismatched++; $display("FAIL bypass_instr: got %h expected 77777777", decode_issue_instruction); end
    compared++; if (decode_issue_PC !== 64'h7000) begin mismatched++; $display("FAIL bypass_pc: got %h expected 7000", decode_issue_PC); end
    tick(); idle(); settle();
    compared++; if (decode_issue_valid !== 1'b0) begin mismatched++; $display("FAIL bypass_after: got %b expected 0", decode_issue_valid); end
    compared++; if (occupancy !== 4'd0) begin mismatched++; $display("FAIL bypass_occ: got %0d expected 0", occupancy); end
    compared++; if (fetch_issue_tag !== {epoch_m, 3'(s + 1)}) begin mismatched++; $display("FAIL bypass_tag: got %b expected %b", fetch_issue_tag, {epoch_m, 3'(s + 1)}); end
    tail_m = (s + 1) % 8;
  endtask
`endif

  task automatic test_full();
    int s;
    s = tail_m;
    for (int i = 0; i < 8; i++) begin
      fetch_issue_valid = 1'b1; fetch_issue_PC = 64'h3000 + 64'(4 * i); settle();
      compared++; if (fetch_issue_ready !== 1'b1) begin mismatched++; $display("FAIL full_fill_ready%0d: got %b expected 1", i, fetch_issue_ready); end
      tick();
    end
    fetch_issue_PC = 64'h3FFF; settle();
    compared++; if (occupancy !== 4'd8) begin mismatched++; $display("FAIL full_occ: got %0d expected 8", occupancy); end
    compared++; if (fetch_issue_ready !== 1'b0) begin mismatched++; $display("FAIL full_ready: got %b expected 0", fetch_issue_ready); end
    tick(); fetch_issue_valid = 1'b0;
    respond({epoch_m, 3'(s)}, {32'h3000_0001, 32'h3000_0000}); tick(); fetch_response_valid = 1'b0; settle();
    compared++; if (decode_issue_valid !== 1'b1) begin mismatched++; $display("FAIL full_head_dvalid: got %b expected 1", decode_issue_valid); end
    compared++; if (decode_issue_instruction !== 32'h3000_0000) begin mismatched++; $display("FAIL full_head_instr: got %h expected 30000000", decode_issue_instruction); end
    decode_issue_ready = 1'b1; fetch_issue_valid = 1'b1; settle();
    compared++; if (fetch_issue_ready !== 1'b0) begin mismatched++; $display("FAIL full_pop_cycle_ready: got %b expected 0", fetch_issue_ready); end
    tick(); idle(); settle();
    compared++; if (fetch_issue_ready !== 1'b1) begin mismatched++; $display("FAIL full_after_pop_ready: got %b expected 1", fetch_issue_ready); end
    compared++; if (occupancy !== 4'd7) begin mismatched++; $display("FAIL full_after_pop_occ: got %0d expected 7", occupancy); end
    compared++; if (decode_issue_PC !== 64'h3004) begin mismatched++; $display("FAIL full_next_head_pc: got %h expected 3004", decode_issue_PC); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reorder();
    test_dup_unissued();
    test_flush();
`ifdef FETCH_RECV_BYPASS_EN
    test_bypass();
`endif
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_receive_tagged.md
Name: fetch_receive_tagged

Overview:
- Next-generation I-cache fetch-receive MSHR/reorder buffer between fetch issue and decode.
- Each request gets a tag {epoch, slot}, returned by the I-cache, so response matching uses a tag compare instead of a PC CAM.
- Flush bumps the epoch, so late responses from before the flush are discarded by tag.
- Generalised in depth (no wasted slot), cache line width (word select by PC) and epoch width. Instructions reach decode strictly in issue order.

Parameters:
- XLEN, 64, PC width.
- SLOT_WIDTH, 3, log2 of slot count; SLOTS = 2**SLOT_WIDTH.
- LINE_WIDTH, 64, response data width in bits; power of two, ≥32.
- EPOCH_WIDTH, 2, flush-epoch tag bits (≥1).
- TAG_WIDTH, EPOCH_WIDTH+SLOT_WIDTH, derived; not overridden.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fetch_issue_valid  in  1  fetch issue has a PC
- fetch_issue_ready  out  1  slot free and no flush
- fetch_issue_PC  in  XLEN  request PC
- fetch_issue_NLP_BTB_hit  in  1  BTB hit flag carried to decode
- fetch_issue_tag  out  TAG_WIDTH  {epoch, tail}; fetch attaches it to the I-cache request
- fetch_response_valid  in  1  I-cache response present
- fetch_response_ready  out  1  constant 1
- fetch_response_instruction  in  LINE_WIDTH  response line
- fetch_response_tag  in  TAG_WIDTH  tag echoed by I-cache
- decode_issue_valid  out  1  head instruction available
- decode_issue_ready  in  1  decode accepts
- decode_issue_instruction  out  32  selected word
- decode_issue_PC  out  XLEN  head PC
- decode_issue_NLP_BTB_hit  out  1  head BTB flag
- flush  in  1  discard all outstanding entries
- occupancy  out  SLOT_WIDTH+1  number of allocated slots

Behaviour:
- State:
  - head, tail: SLOT_WIDTH bits, wrap naturally.
  - count: 0..SLOTS.
  - epoch: EPOCH_WIDTH bits.
  - Per slot: issued, received, PC, NLP_BTB_hit, instruction[31:0].
- Reset: head=tail=count=epoch=0; all issued/received/PC/BTB cleared. Resulting outputs:
  - fetch_issue_ready=1, decode_issue_valid=0, occupancy=0, fetch_issue_tag=0.
  - decode_issue_PC=0 and decode_issue_NLP_BTB_hit=0; decode_issue_instruction is don't-care.
- Issue:
  - fetch_issue_ready = (count != SLOTS) && !flush. All SLOTS are usable.
  - On valid&&ready: slot[tail] gets issued=1, received=0, PC, BTB flag; tail++.
- Response:
  - Accept when valid && tag.epoch==epoch && issued[tag.slot] && !received[tag.slot] && !flush.
  - On accept: received=1; instruction = word PC[slot][log2(LINE_WIDTH/8)-1:2] of the line (word 0 when LINE_WIDTH=32).
  - Any other response is silently dropped: stale epoch, unissued slot, duplicate, or flush cycle.
- Decode:
  - decode_issue_valid = received[head] && count!=0 && !flush.
  - On valid&&ready: issued[head]=received[head]=0; head++.
- count: +1 on issue, -1 on decode pop, unchanged when both occur in the same cycle. occupancy = count.
- Latency: a response accepted in cycle N gives decode_issue_valid in N+1 at the earliest (without bypass).
- Flush (priority over everything except reset):
  - Next cycle: head=tail=count=0; all issued/received cleared; epoch++ (wraps).
  - Issue, response and decode in the flush cycle all have no effect.
- Stale-epoch alias: after 2**EPOCH_WIDTH flushes with a response still in flight, that response could alias. The I-cache guarantees in-flight lifetime < 2**EPOCH_WIDTH flushes; the bench does not cover that case.
- Full: count==SLOTS → issue blocked; a same-cycle decode pop does not re-open ready in that cycle.
- Empty: count==0 → decode_issue_valid=0 regardless of stale received bits.
- Out-of-order responses: stored; decode still waits for the head slot.

Optional Feature:
- Macro FETCH_RECV_BYPASS_EN. Defined: an accepted response whose slot==head is forwarded combinationally.
  - decode_issue_valid is 1 in the response cycle, decode_issue_instruction is the selected word from the response.
  - If decode_issue_ready is also high, head advances and received[head] is not written. Otherwise received is written as normal.
- Undefined: minimum 1-cycle response-to-decode latency as specified above.

Decomposition:
- Shared package:
  - tag field layout: epoch in the MSBs, slot in the LSBs.
  - word-select offset function: log2(LINE_WIDTH/8).
- Natural sub-module: fetch_word_select, a combinational line→32-bit word mux by PC offset. Reused for both the stored path and the bypass path.

Test Plan:
- In-order: issue PCs 0x1000, 0x1004, 0x1008; responses with tags 0,1,2, line words 0x00000013 and 0x00100093 → decode sees 0x1000/0x00000013, 0x1004/0x00100093, 0x1008 in order, each 1 cycle after its response.
- Reorder: issue 4 PCs; respond with tags 3,1,0,2 → decode valid first only after tag 0, then the 4 instructions come out back-to-back in issue order.
- Full: issue 8 with decode stalled → occupancy=8, fetch_issue_ready=0; one decode pop → ready=1 next cycle, occupancy=7.
- Flush: 3 outstanding, assert flush, then respond with old tags {0,0..2} → all dropped, epoch=1, next fetch_issue_tag=0b01_000, occupancy=0.
- Duplicate/unissued: a response to the same tag twice returns the first data; a response to an unissued slot is ignored with no decode_issue_valid.
- Bypass (macro on): head outstanding, response tag=head with decode_issue_ready=1 → decode_issue_valid in the same cycle, head+1 next cycle.
